// File: rtl/spi_slave_if.sv
// SPI link pins plus the local register-bus side of the SPI mode-0 responder.
// The slave modport is the responder's view; master is the peer/register-bank view.
interface spi_slave_if;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_wr;
  logic       reg_rd;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  sclk, ss, mosi, reg_rdata,
    output miso, reg_addr, reg_wdata, reg_wr, reg_rd, frame_done, frame_err, busy
  );

  modport master (
    output sclk, ss, mosi, reg_rdata,
    input  miso, reg_addr, reg_wdata, reg_wr, reg_rd, frame_done, frame_err, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/ss/mosi, decodes 24-bit ID/addr/data frames
// and drives a register bus; read frames return reg_rdata on miso.
module spi_slave #(
  parameter logic [7:0] SLAVE_IDW   = 8'hFF,
  parameter logic [7:0] SLAVE_IDR   = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        n_reset,
  spi_slave_if.slave  bus
);

  localparam int TOP = SYNC_STAGES - 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ID      = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_WAIT_SS = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] valid_q, valid_d;
  logic       sclk_dly_q, sclk_dly_d;
  logic       ss_dly_q, ss_dly_d;
  logic       armed_q, armed_d;
  logic [2:0] state_q, state_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       miso_q, miso_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_s    = sclk_sync_q[TOP];
  assign ss_s      = ss_sync_q[TOP];
  assign mosi_s    = mosi_sync_q[TOP];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ss_rise   = ss_s & ~ss_dly_q;
  assign ss_fall   = ~ss_s & ss_dly_q;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], bus.ss};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    valid_d      = {valid_q[SYNC_STAGES-2:0], 1'b1};
    sclk_dly_d   = sclk_s;
    ss_dly_d     = ss_s;
    // The reset value of the ss synchronizer is not a real observation, so a
    // frame may only start once ss has genuinely been seen high after reset.
    armed_d      = armed_q | (valid_q[TOP] & ss_s);
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    rw_d         = rw_q;
    miso_d       = miso_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_wr_d     = 1'b0;
    reg_rd_d     = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = busy_q;

    if (state_q != ST_IDLE && ss_rise) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      miso_d       = 1'b0;
      frame_done_d = 1'b1;
      // A bad-ID frame already reported its error on the 8th bit.
      frame_err_d  = (state_q != ST_WAIT_SS) && (bit_cnt_q < 5'd24);
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (ss_fall && armed_q) begin
            state_d   = ST_ID;
            bit_cnt_d = 5'd0;
            shift_d   = 8'h00;
            busy_d    = 1'b1;
          end
        end
        ST_ID: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              if (shift_d == SLAVE_IDW) begin
                rw_d    = 1'b1;
                state_d = ST_ADDR;
              end else if (shift_d == SLAVE_IDR) begin
                rw_d    = 1'b0;
                state_d = ST_ADDR;
              end else begin
                frame_err_d = 1'b1;
                state_d     = ST_WAIT_SS;
              end
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              reg_addr_d = shift_d;
              reg_rd_d   = ~rw_q;
              state_d    = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              reg_wdata_d = shift_d;
              reg_wr_d    = rw_q;
              state_d     = ST_WAIT_SS;
            end
          end else if (sclk_fall && !rw_q) begin
            // First fall of the data byte loads the read data; later falls shift it out.
            if (bit_cnt_q == 5'd16) begin
              miso_d = bus.reg_rdata[7];
              tx_d   = {bus.reg_rdata[6:0], 1'b0};
            end else begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end
          end
        end
        ST_WAIT_SS: begin
          if (sclk_fall) begin
            miso_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sclk_sync_q  <= '0;
      ss_sync_q    <= '1;
      mosi_sync_q  <= '0;
      valid_q      <= '0;
      sclk_dly_q   <= 1'b0;
      ss_dly_q     <= 1'b1;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 5'd0;
      shift_q      <= 8'h00;
      tx_q         <= 8'h00;
      rw_q         <= 1'b0;
      miso_q       <= 1'b0;
      reg_addr_q   <= 8'h00;
      reg_wdata_q  <= 8'h00;
      reg_wr_q     <= 1'b0;
      reg_rd_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      ss_sync_q    <= ss_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      valid_q      <= valid_d;
      sclk_dly_q   <= sclk_dly_d;
      ss_dly_q     <= ss_dly_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      rw_q         <= rw_d;
      miso_q       <= miso_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wr_q     <= reg_wr_d;
      reg_rd_q     <= reg_rd_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.miso       = miso_q;
  assign bus.reg_addr   = reg_addr_q;
  assign bus.reg_wdata  = reg_wdata_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.reg_rd     = reg_rd_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule
